io_cmd_dispatcher: RTL and testbench

Command queue and issue sequencer directly upstream of the I/O execution unit. It buffers I/O commands from the controller core and presents them one at a time on the unit's instruction port (`instrucction`, `register`, `auxiliar_register`, `valid_instrucction`). It holds each command stable until the unit drops `busy`, then captures read results (`valid_io`, `result_input_io`) into a response register with a ready/valid handshake.

---
 rtl/io_cmd_dispatcher.sv | 217 +++++++++++++++++++++
 tb/tb_io_cmd_dispatcher.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_cmd_dispatcher.sv
// io_cmd_dispatcher: command FIFO plus one-at-a-time issue sequencer in front of the I/O execution unit.
// Define IO_DISPATCH_TIMEOUT_EN to add the wait-state watchdog, the sticky err_timeout flag and the DRAIN state.

module io_cmd_dispatcher #(
  parameter int          DEPTH            = 4,
  parameter int          INSTRUCTION_SIZE = 3,
  parameter int          REG_SIZE         = 5,
  parameter int          AUXILIAR_SIZE    = 44,
  parameter int          IO_OUTPUT_SIZE   = 8,
  parameter logic [47:0] TIMEOUT_CYCLES   = 48'h0000EE6B2800
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [INSTRUCTION_SIZE-1:0] cmd_opcode,
  input  logic [REG_SIZE-1:0]         cmd_register,
  input  logic [AUXILIAR_SIZE-1:0]    cmd_aux,
  output logic [INSTRUCTION_SIZE-1:0] instrucction,
  output logic [REG_SIZE-1:0]         register,
  output logic [AUXILIAR_SIZE-1:0]    auxiliar_register,
  output logic                        valid_instrucction,
  input  logic                        busy,
  input  logic                        valid_io,
  input  logic [IO_OUTPUT_SIZE-1:0]   result_input_io,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IO_OUTPUT_SIZE-1:0]   rsp_data,
  output logic [INSTRUCTION_SIZE-1:0] rsp_opcode,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        idle,
  output logic                        err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef IO_DISPATCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

  function automatic logic isReadOp(input logic [INSTRUCTION_SIZE-1:0] op);
    return (op == INSTRUCTION_SIZE'(3'b100)) ||
           (op == INSTRUCTION_SIZE'(3'b101)) ||
           (op == INSTRUCTION_SIZE'(3'b110));
  endfunction

  state_t                      state_q;

  logic [INSTRUCTION_SIZE-1:0] opMem  [DEPTH];
  logic [REG_SIZE-1:0]         regMem [DEPTH];
  logic [AUXILIAR_SIZE-1:0]    auxMem [DEPTH];

  logic [AW-1:0]               wrPtr_q, wrPtr_d;
  logic [AW-1:0]               rdPtr_q, rdPtr_d;
  logic [LW-1:0]               level_q, level_d;

  logic [INSTRUCTION_SIZE-1:0] instr_q;
  logic [REG_SIZE-1:0]         reg_q;
  logic [AUXILIAR_SIZE-1:0]    aux_q;
  logic                        validInstr_q;
  logic                        rspValid_q;
  logic [IO_OUTPUT_SIZE-1:0]   rspData_q;
  logic [INSTRUCTION_SIZE-1:0] rspOpcode_q;

  logic                        push;
  logic                        pop;
  logic                        fifoEmpty;
  logic                        headIsRead;

  assign fifoEmpty  = (level_q == '0);
  assign cmd_ready  = (level_q != LW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign headIsRead = isReadOp(opMem[rdPtr_q]);

  // A read may only leave the FIFO once the response register is free, so a
  // capture can never collide with an unconsumed result.
  assign pop = (state_q == IDLE) && !fifoEmpty && !busy && !(headIsRead && rspValid_q);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      opMem[wrPtr_q]  <= cmd_opcode;
      regMem[wrPtr_q] <= cmd_register;
      auxMem[wrPtr_q] <= cmd_aux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

`ifdef IO_DISPATCH_TIMEOUT_EN
  logic [47:0] waitCnt_q;
  logic        errTimeout_q;
  logic        timeoutHit;

  // The count is cumulative across WAIT_BUSY and WAIT_DONE for one command.
  assign timeoutHit  = (waitCnt_q == TIMEOUT_CYCLES - 48'd1);
  assign err_timeout = errTimeout_q;
`else
  assign err_timeout = 1'b0 & (TIMEOUT_CYCLES != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      reg_q        <= '0;
      aux_q        <= '0;
      validInstr_q <= 1'b0;
      rspValid_q   <= 1'b0;
      rspData_q    <= '0;
      rspOpcode_q  <= '0;
`ifdef IO_DISPATCH_TIMEOUT_EN
      waitCnt_q    <= '0;
      errTimeout_q <= 1'b0;
`endif
    end else begin
      validInstr_q <= 1'b0;
      if (rspValid_q && rsp_ready) rspValid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pop) begin
            instr_q      <= opMem[rdPtr_q];
            reg_q        <= regMem[rdPtr_q];
            aux_q        <= auxMem[rdPtr_q];
            validInstr_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end

        ISSUE: begin
          state_q <= WAIT_BUSY;
`ifdef IO_DISPATCH_TIMEOUT_EN
          waitCnt_q <= '0;
`endif
        end

        WAIT_BUSY: begin
`ifdef IO_DISPATCH_TIMEOUT_EN
          waitCnt_q <= waitCnt_q + 48'd1;
`endif
          if (busy) state_q <= WAIT_DONE;
`ifdef IO_DISPATCH_TIMEOUT_EN
          else if (timeoutHit) begin
            errTimeout_q <= 1'b1;
            state_q      <= DRAIN;
          end
`endif
        end

        WAIT_DONE: begin
`ifdef IO_DISPATCH_TIMEOUT_EN
          waitCnt_q <= waitCnt_q + 48'd1;
`endif
          if (!busy) begin
            state_q <= IDLE;
            if (isReadOp(instr_q) && valid_io) begin
              rspData_q   <= result_input_io;
              rspOpcode_q <= instr_q;
              rspValid_q  <= 1'b1;
            end
          end
`ifdef IO_DISPATCH_TIMEOUT_EN
          else if (timeoutHit) begin
            errTimeout_q <= 1'b1;
            state_q      <= DRAIN;
          end
`endif
        end

`ifdef IO_DISPATCH_TIMEOUT_EN
        DRAIN: begin
          if (!busy) state_q <= IDLE;
        end
`endif

        default: state_q <= IDLE;
      endcase
    end
  end

  assign instrucction       = instr_q;
  assign register           = reg_q;
  assign auxiliar_register  = aux_q;
  assign valid_instrucction = validInstr_q;
  assign rsp_valid          = rspValid_q;
  assign rsp_data           = rspData_q;
  assign rsp_opcode         = rspOpcode_q;
  assign fifo_level         = level_q;
  assign idle               = fifoEmpty && (state_q == IDLE);

endmodule

// File: tb/tb_io_cmd_dispatcher.sv
// Scoreboard bench for io_cmd_dispatcher: directed commands feed expected-issue and expected-response queues,
// a monitor pops them as the DUT strobes, and a small I/O-unit model answers every issued command.

module tb_io_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [4:0]  cmd_register;
  logic [43:0] cmd_aux;
  logic [2:0]  instrucction;
  logic [4:0]  register;
  logic [43:0] auxiliar_register;
  logic        valid_instrucction;
  logic        busy;
  logic        busyUnit;
  logic        forceBusy;
  logic        valid_io;
  logic [7:0]  result_input_io;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [2:0]  rsp_opcode;
  logic [2:0]  fifo_level;
  logic        idle;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int unitLen = 3;

  logic [51:0] expIssue[$];
  logic [10:0] expRsp[$];

  assign busy = busyUnit | forceBusy;

  always #5 clk = ~clk;

  io_cmd_dispatcher dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_opcode         (cmd_opcode),
    .cmd_register       (cmd_register),
    .cmd_aux            (cmd_aux),
    .instrucction       (instrucction),
    .register           (register),
    .auxiliar_register  (auxiliar_register),
    .valid_instrucction (valid_instrucction),
    .busy               (busy),
    .valid_io           (valid_io),
    .result_input_io    (result_input_io),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_opcode         (rsp_opcode),
    .fifo_level         (fifo_level),
    .idle               (idle),
    .err_timeout        (err_timeout)
  );

  function automatic bit isRead(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one command and wait (bounded) until the FIFO takes it.
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rg,
                               input logic [43:0] aux, input logic [7:0] expData);
    bit r;
    bit accepted;
    accepted = 1'b0;
    expIssue.push_back({op, rg, aux});
    if (isRead(op)) expRsp.push_back({op, expData});
    cmd_valid    = 1'b1;
    cmd_opcode   = op;
    cmd_register = rg;
    cmd_aux      = aux;
    for (int i = 0; i < 300 && !accepted; i++) begin
      r = cmd_ready;
      tick(1);
      if (r) accepted = 1'b1;
    end
    cmd_valid = 1'b0;
    checkOutput("pushAccepted", {63'd0, accepted}, 64'd1);
  endtask

  task automatic waitIdle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (idle) ok = 1'b1;
      else tick(1);
    end
    checkOutput("drainIdle", {63'd0, ok}, 64'd1);
    tick(2);
  endtask

  task automatic waitRsp(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (rsp_valid) ok = 1'b1;
      else tick(1);
    end
    checkOutput("rspArrives", {63'd0, ok}, 64'd1);
  endtask

  task automatic consumeRsp;
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    checkOutput("rspCleared", {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic unitStep(output bit ab);
    @(posedge clk);
    #1;
    ab = rst;
  endtask

  // I/O unit model: busy follows the strobe by one edge, lasts unitLen cycles
  // (one cycle for the zero-delay read) and returns aux[7:0] ^ register on reads.
  initial begin : unitModel
    bit          ab;
    logic [2:0]  uOp;
    logic [4:0]  uReg;
    logic [43:0] uAux;
    int          len;
    busyUnit        = 1'b0;
    valid_io        = 1'b0;
    result_input_io = '0;
    forever begin
      unitStep(ab);
      if (!ab && valid_instrucction) begin
        uOp  = instrucction;
        uReg = register;
        uAux = auxiliar_register;
        len  = (uOp == 3'b110) ? 1 : unitLen;
        unitStep(ab);
        if (!ab) begin
          busyUnit = 1'b1;
          for (int k = 1; k < len && !ab; k++) unitStep(ab);
          if (!ab) unitStep(ab);
        end
        busyUnit = 1'b0;
        if (!ab) begin
          valid_io        = isRead(uOp);
          result_input_io = uAux[7:0] ^ {3'b000, uReg};
          unitStep(ab);
        end
        valid_io = 1'b0;
      end
    end
  end

  // Monitor: compares every issue strobe and every consumed response against the queues.
  initial begin : monitor
    logic [51:0] lastIssue;
    logic [51:0] exp52;
    logic [10:0] exp11;
    bit          prevValid;
    lastIssue = '0;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lastIssue = '0;
        prevValid = 1'b0;
      end else begin
        if (valid_instrucction) begin
          checkOutput("strobeWidth", {63'd0, prevValid}, 64'd0);
          if (expIssue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedIssue actual=0x%0h expected=none",
                     {instrucction, register, auxiliar_register});
          end else begin
            exp52 = expIssue.pop_front();
            checkOutput("issueOrder", {12'd0, instrucction, register, auxiliar_register}, {12'd0, exp52});
          end
          lastIssue = {instrucction, register, auxiliar_register};
        end else if (busy) begin
          checkOutput("heldOutputs", {12'd0, instrucction, register, auxiliar_register}, {12'd0, lastIssue});
        end
        prevValid = valid_instrucction;
        if (rsp_valid && rsp_ready) begin
          if (expRsp.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRsp actual=0x%0h expected=none", {rsp_opcode, rsp_data});
          end else begin
            exp11 = expRsp.pop_front();
            checkOutput("rspPayload", {53'd0, rsp_opcode, rsp_data}, {53'd0, exp11});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL globalTimeout actual=running expected=finished");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    rst          = 1'b1;
    forceBusy    = 1'b0;
    cmd_valid    = 1'b0;
    cmd_opcode   = '0;
    cmd_register = '0;
    cmd_aux      = '0;
    rsp_ready    = 1'b0;
    tick(3);
    checkOutput("resetCmdReady", {63'd0, cmd_ready}, 64'd1);
    checkOutput("resetIdle", {63'd0, idle}, 64'd1);
    checkOutput("resetLevel", {61'd0, fifo_level}, 64'd0);
    checkOutput("resetStrobe", {63'd0, valid_instrucction}, 64'd0);
    checkOutput("resetErrTimeout", {63'd0, err_timeout}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick(1);

    $display("[TB] write issue latency and hold");
    applyStimulus(3'b000, 5'd5, 44'd10, 8'h00);
    checkOutput("wrLevelAfterPush", {61'd0, fifo_level}, 64'd1);
    checkOutput("wrStrobeBeforeE1", {63'd0, valid_instrucction}, 64'd0);
    tick(1);
    checkOutput("wrStrobeAfterE1", {63'd0, valid_instrucction}, 64'd1);
    checkOutput("wrLevelAfterPop", {61'd0, fifo_level}, 64'd0);
    checkOutput("wrRegister", {59'd0, register}, 64'd5);
    checkOutput("wrAux", {20'd0, auxiliar_register}, 64'd10);
    tick(1);
    checkOutput("wrStrobeAfterE2", {63'd0, valid_instrucction}, 64'd0);
    checkOutput("wrNotIdle", {63'd0, idle}, 64'd0);
    @(negedge clk);
    checkOutput("wrUnitBusy", {63'd0, busy}, 64'd1);
    tick(1);
    waitIdle(50);
    checkOutput("wrNoRsp", {63'd0, rsp_valid}, 64'd0);

    $display("[TB] zero-delay read response latency");
    applyStimulus(3'b110, 5'd5, 44'hA0, 8'hA5);
    tick(3);
    checkOutput("rdRspBeforeE4", {63'd0, rsp_valid}, 64'd0);
    tick(1);
    checkOutput("rdRspAfterE4", {63'd0, rsp_valid}, 64'd1);
    checkOutput("rdRspData", {56'd0, rsp_data}, 64'hA5);
    checkOutput("rdRspOpcode", {61'd0, rsp_opcode}, 64'd6);
    consumeRsp();
    waitIdle(50);

    $display("[TB] back-to-back reads with consumer stalled");
    applyStimulus(3'b100, 5'd3, 44'h30, 8'h33);
    applyStimulus(3'b101, 5'd1, 44'h5A, 8'h5B);
    tick(20);
    checkOutput("rdSecondHeld", {61'd0, fifo_level}, 64'd1);
    checkOutput("rdFirstValid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("rdFirstData", {56'd0, rsp_data}, 64'h33);
    consumeRsp();
    waitRsp(100);
    checkOutput("rdSecondData", {56'd0, rsp_data}, 64'h5B);
    checkOutput("rdSecondOpcode", {61'd0, rsp_opcode}, 64'd5);
    consumeRsp();
    waitIdle(50);

    $display("[TB] fill FIFO while unit stalled, then drain in order");
    forceBusy = 1'b1;
    tick(1);
    applyStimulus(3'b000, 5'd1, 44'h111, 8'h00);
    applyStimulus(3'b001, 5'd2, 44'h222, 8'h00);
    applyStimulus(3'b010, 5'd3, 44'h333, 8'h00);
    applyStimulus(3'b011, 5'd4, 44'h444, 8'h00);
    checkOutput("fullLevel", {61'd0, fifo_level}, 64'd4);
    checkOutput("fullNotReady", {63'd0, cmd_ready}, 64'd0);
    fork
      applyStimulus(3'b111, 5'd6, 44'hFFF_0000_0555, 8'h00);
      begin
        tick(3);
        forceBusy = 1'b0;
      end
    join
    waitIdle(300);
    checkOutput("writesNoRsp", {63'd0, rsp_valid}, 64'd0);

    $display("[TB] asynchronous reset during WAIT_DONE");
    unitLen = 20;
    applyStimulus(3'b011, 5'd7, 44'hABC_DEF0_1234, 8'h00);
    applyStimulus(3'b001, 5'd1, 44'd1, 8'h00);
    applyStimulus(3'b010, 5'd2, 44'd2, 8'h00);
    tick(4);
    @(negedge clk);
    checkOutput("preRstBusy", {63'd0, busy}, 64'd1);
    checkOutput("preRstLevel", {61'd0, fifo_level}, 64'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstLevel", {61'd0, fifo_level}, 64'd0);
    checkOutput("rstIdle", {63'd0, idle}, 64'd1);
    checkOutput("rstCmdReady", {63'd0, cmd_ready}, 64'd1);
    checkOutput("rstInstr", {61'd0, instrucction}, 64'd0);
    checkOutput("rstRegister", {59'd0, register}, 64'd0);
    checkOutput("rstAux", {20'd0, auxiliar_register}, 64'd0);
    checkOutput("rstRspData", {56'd0, rsp_data}, 64'd0);
    checkOutput("rstRspOpcode", {61'd0, rsp_opcode}, 64'd0);
    checkOutput("rstRspValid", {63'd0, rsp_valid}, 64'd0);
    expIssue.delete();
    unitLen = 3;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    tick(1);

    $display("[TB] recovery after reset");
    applyStimulus(3'b001, 5'd2, 44'd3, 8'h00);
    waitIdle(50);
    checkOutput("issueQueueEmpty", 64'(expIssue.size()), 64'd0);
    checkOutput("rspQueueEmpty", 64'(expRsp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
